hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Parametrised hazard control unit for the pipelined CPU. It sits beside the ID stage and drives the PC, IF/ID and ID/EX control-mux enables. It covers three cases:
- load-use stalls of configurable length, ignoring the zero register;
- taken-branch flushes (B, B.LT, CBZ resolved in EX) with a configurable penalty;
- full-pipeline freeze while data memory is busy.

It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- REG_W, 5, register-address width
- ZERO_REG, 31, register index that never creates a dependency (XZR)
- LOAD_STALL, 1, bubbles inserted per load-use hazard; legal 1..7
- BR_PENALTY, 1, cycles IF/ID is flushed after a taken branch; legal 1..4
- CNT_W, 16, width of stall_cycles

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- id_rn  in  REG_W  ID-stage first source register
- id_rm  in  REG_W  ID-stage second source register
- id_uses_rn  in  1  ID instruction reads id_rn
- id_uses_rm  in  1  ID instruction reads id_rm
- ex_rd  in  REG_W  ID/EX destination register
- ex_mem_read  in  1  ID/EX instruction is a load
- br_taken  in  1  branch in EX resolved taken this cycle
- dmem_busy  in  1  data memory not ready; pipeline must freeze
- pc_write  out  1  PC register enable
- if_id_write  out  1  IF/ID register enable
- ctrl_sel  out  1  1 passes ID control to ID/EX; 0 inserts bubble (zero control)
- if_id_flush  out  1  clear IF/ID to NOP
- id_ex_flush  out  1  clear ID/EX to NOP
- pipe_freeze  out  1  hold all stage registers (EX/MEM, MEM/WB included)
- stall_cycles  out  CNT_W  saturating count of stalled/frozen cycles

## Operation
- States: RUN, LSTALL, BFLUSH. A down-counter `cnt` (3 bits) is shared by LSTALL and BFLUSH.
- Outputs are combinational from state, `cnt` and the current inputs. Hazards act in the same cycle they are detected.
- Pass-through outputs: pc_write=1, if_id_write=1, ctrl_sel=1, all flushes=0, pipe_freeze=0.
- Load-use hazard (luh) = ex_mem_read && ex_rd!=ZERO_REG && ((id_uses_rn && id_rn==ex_rd) || (id_uses_rm && id_rm==ex_rd)).
- Priority each cycle: reset > dmem_busy > br_taken > luh > state action.

dmem_busy:
- pipe_freeze=1, pc_write=0, if_id_write=0.
- ctrl_sel=1 and flushes=0.
- State and `cnt` hold.
- br_taken and luh are ignored; they are re-evaluated after busy drops, because the frozen stages keep them stable.

br_taken (any state):
- pc_write=1, if_id_flush=1, id_ex_flush=1, ctrl_sel=1.
- If BR_PENALTY>1: go to BFLUSH with cnt=BR_PENALTY-1; otherwise go to RUN.
- A pending load stall is abandoned.

BFLUSH:
- if_id_flush=1, pc_write=1.
- Decrement `cnt`; return to RUN when cnt reaches 0.
- luh is ignored, since ID holds a flushed NOP.

luh in RUN:
- pc_write=0, if_id_write=0, ctrl_sel=0.
- If LOAD_STALL>1: go to LSTALL with cnt=LOAD_STALL-1; otherwise stay in RUN.

LSTALL:
- Same stall outputs as luh in RUN; decrement `cnt`; go to RUN when cnt reaches 0.
- A new luh in RUN immediately after LSTALL is evaluated normally.

stall_cycles:
- Increments in every cycle where pc_write==0 (load stall or freeze).
- Saturates at 2^CNT_W-1.

## Timing
- Reset: state=RUN, cnt=0, stall_cycles=0.
- While reset is high, outputs are pass-through regardless of other inputs.
- Outputs are valid from the first cycle after reset deasserts.
- Load-use: exactly LOAD_STALL consecutive stall cycles, starting in the detection cycle.
- Branch: flush in the resolution cycle, then BR_PENALTY-1 further IF/ID flush cycles.
- Freeze cycles inserted mid-LSTALL or mid-BFLUSH extend it; no stall or flush cycle is lost.
- Reset asserted mid-LSTALL or mid-BFLUSH: back to RUN on the next edge; the counter is cleared.
- No combinational path from stall_cycles to other outputs.

## Test plan
- LOAD_STALL=1: ex_mem_read=1, ex_rd=3, id_rn=3, id_uses_rn=1 -> one cycle pc_write=0/if_id_write=0/ctrl_sel=0, then pass-through; stall_cycles=1.
- ex_rd=31 with id_rm=31, and separately matching id_rn with id_uses_rn=0 -> no stall.
- LOAD_STALL=3: hazard held -> 3 stall cycles; dmem_busy pulsed for 2 cycles mid-stall -> 5 cycles with pc_write=0 total, still 3 bubbles; stall_cycles=5.
- BR_PENALTY=2: br_taken with simultaneous luh -> cycle 0: pc_write=1, both flushes=1, ctrl_sel=1; cycle 1: if_id_flush=1 only; cycle 2: pass-through.
- br_taken during LSTALL (LOAD_STALL=4, cycle 2) -> stall abandoned, flush issued that cycle; reset during BFLUSH -> pass-through next cycle, stall_cycles=0.
- CNT_W=4: 20 consecutive dmem_busy cycles -> stall_cycles saturates at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard control unit beside the ID stage.
// Resolves load-use stalls, taken-branch flushes and data-memory freezes,
// and keeps a saturating count of cycles in which the PC was held.
module hazard_ctrl #(
    parameter int REG_W      = 5,
    parameter int ZERO_REG   = 31,
    parameter int LOAD_STALL = 1,
    parameter int BR_PENALTY = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_uses_rn,
    input  logic             id_uses_rm,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             br_taken,
    input  logic             dmem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             ctrl_sel,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             pipe_freeze,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] LSTALL = 2'd1;
    localparam logic [1:0] BFLUSH = 2'd2;

    // Remaining cycles after the detection/resolution cycle itself.
    localparam logic [2:0]       LS_INIT = 3'(LOAD_STALL - 1);
    localparam logic [2:0]       BR_INIT = 3'(BR_PENALTY - 1);
    localparam logic [REG_W-1:0] ZERO    = REG_W'(ZERO_REG);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0] state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       luh;

    // Load-use detection; the zero register never carries a dependency.
    always_comb begin
        luh = ex_mem_read && (ex_rd != ZERO) &&
              ((id_uses_rn && (id_rn == ex_rd)) ||
               (id_uses_rm && (id_rm == ex_rd)));
    end

    // Output decode and next-state selection in priority order:
    // reset, memory freeze, taken branch, load-use / state action.
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        ctrl_sel    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pipe_freeze = 1'b0;
        state_nxt   = state;
        cnt_nxt     = cnt;

        if (reset) begin
            state_nxt = RUN;
            cnt_nxt   = 3'd0;
        end else if (dmem_busy) begin
            // Everything holds; branch and hazard inputs stay stable in the
            // frozen stages and are re-evaluated once memory is ready.
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_freeze = 1'b1;
        end else if (br_taken) begin
            // Any pending load stall is dropped: the dependent instruction
            // is on the wrong path anyway.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (BR_PENALTY > 1) begin
                state_nxt = BFLUSH;
                cnt_nxt   = BR_INIT;
            end else begin
                state_nxt = RUN;
                cnt_nxt   = 3'd0;
            end
        end else begin
            case (state)
                BFLUSH: begin
                    // ID holds a flushed NOP, so luh is meaningless here.
                    if_id_flush = 1'b1;
                    cnt_nxt     = cnt - 3'd1;
                    if (cnt <= 3'd1) begin
                        state_nxt = RUN;
                    end
                end
                LSTALL: begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    ctrl_sel    = 1'b0;
                    cnt_nxt     = cnt - 3'd1;
                    if (cnt <= 3'd1) begin
                        state_nxt = RUN;
                    end
                end
                default: begin
                    if (luh) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        ctrl_sel    = 1'b0;
                        if (LOAD_STALL > 1) begin
                            state_nxt = LSTALL;
                            cnt_nxt   = LS_INIT;
                        end else begin
                            state_nxt = RUN;
                            cnt_nxt   = 3'd0;
                        end
                    end else begin
                        state_nxt = RUN;
                        cnt_nxt   = 3'd0;
                    end
                end
            endcase
        end
    end

    // State and shared down-counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Saturating count of cycles with the PC held (load stall or freeze).
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (!pc_write && (stall_cycles != CNT_MAX)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors against three parameterisations of
// hazard_ctrl sharing one input bus; expectations go into a scoreboard
// queue and a negedge monitor pops and compares them.
module tb_hazard_ctrl;

    localparam logic [5:0] P  = 6'b111000; // pass-through
    localparam logic [5:0] S  = 6'b000000; // load stall bubble
    localparam logic [5:0] F  = 6'b001001; // memory freeze
    localparam logic [5:0] BR = 6'b111110; // branch resolution cycle
    localparam logic [5:0] BF = 6'b111100; // post-branch IF/ID flush

    logic       clk;
    logic       reset;
    logic [4:0] id_rn, id_rm, ex_rd;
    logic       id_uses_rn, id_uses_rm, ex_mem_read, br_taken, dmem_busy;

    logic [5:0]  o_a, o_b, o_c;
    logic [15:0] sc_a, sc_c;
    logic [3:0]  sc_b;

    typedef struct {
        int          sel;
        logic [5:0]  outs;
        logic [15:0] cnt;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // A: LOAD_STALL=1, BR_PENALTY=2
    hazard_ctrl #(.REG_W(5), .ZERO_REG(31), .LOAD_STALL(1), .BR_PENALTY(2), .CNT_W(16)) u_a (
        .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm),
        .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .br_taken(br_taken), .dmem_busy(dmem_busy),
        .pc_write(o_a[5]), .if_id_write(o_a[4]), .ctrl_sel(o_a[3]),
        .if_id_flush(o_a[2]), .id_ex_flush(o_a[1]), .pipe_freeze(o_a[0]),
        .stall_cycles(sc_a));

    // B: LOAD_STALL=3, BR_PENALTY=1, narrow counter
    hazard_ctrl #(.REG_W(5), .ZERO_REG(31), .LOAD_STALL(3), .BR_PENALTY(1), .CNT_W(4)) u_b (
        .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm),
        .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .br_taken(br_taken), .dmem_busy(dmem_busy),
        .pc_write(o_b[5]), .if_id_write(o_b[4]), .ctrl_sel(o_b[3]),
        .if_id_flush(o_b[2]), .id_ex_flush(o_b[1]), .pipe_freeze(o_b[0]),
        .stall_cycles(sc_b));

    // C: LOAD_STALL=4, BR_PENALTY=2
    hazard_ctrl #(.REG_W(5), .ZERO_REG(31), .LOAD_STALL(4), .BR_PENALTY(2), .CNT_W(16)) u_c (
        .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm),
        .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .br_taken(br_taken), .dmem_busy(dmem_busy),
        .pc_write(o_c[5]), .if_id_write(o_c[4]), .ctrl_sel(o_c[3]),
        .if_id_flush(o_c[2]), .id_ex_flush(o_c[1]), .pipe_freeze(o_c[0]),
        .stall_cycles(sc_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic rst, input logic busy, input logic br,
                         input logic mr, input logic [4:0] rd,
                         input logic [4:0] rn, input logic urn,
                         input logic [4:0] rm, input logic urm);
        @(posedge clk);
        #1;
        reset       = rst;
        dmem_busy   = busy;
        br_taken    = br;
        ex_mem_read = mr;
        ex_rd       = rd;
        id_rn       = rn;
        id_uses_rn  = urn;
        id_rm       = rm;
        id_uses_rm  = urm;
    endtask

    task automatic chk(input int sel, input logic [5:0] o, input int c, input string tag);
        exp_t e;
        e.sel  = sel;
        e.outs = o;
        e.cnt  = 16'(c);
        e.tag  = tag;
        sb.push_back(e);
    endtask

    // Monitor: compare every queued expectation against the selected DUT.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t        e;
            logic [5:0]  ao;
            logic [15:0] ac;
            e = sb.pop_front();
            case (e.sel)
                0:       begin ao = o_a; ac = sc_a; end
                1:       begin ao = o_b; ac = {12'd0, sc_b}; end
                default: begin ao = o_c; ac = sc_c; end
            endcase
            checks++;
            if (ao !== e.outs || ac !== e.cnt) begin
                errors++;
                $display("FAIL %s dut=%0d outs got %b want %b stall_cycles got %0d want %0d",
                         e.tag, e.sel, ao, e.outs, ac, e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; dmem_busy = 1'b0; br_taken = 1'b0; ex_mem_read = 1'b0;
        ex_rd = '0; id_rn = '0; id_rm = '0; id_uses_rn = 1'b0; id_uses_rm = 1'b0;

        // Reset overrides a live hazard
        drive(1, 0, 0, 1, 3, 3, 1, 0, 0);
        chk(0, P, 0, "rst_a"); chk(1, P, 0, "rst_b"); chk(2, P, 0, "rst_c");
        drive(1, 0, 1, 1, 3, 3, 1, 0, 0);
        chk(0, P, 0, "rst_br_a");

        // LOAD_STALL=1 single bubble
        drive(0, 0, 0, 1, 3, 3, 1, 0, 0); chk(0, S, 0, "ls1_stall");
        drive(0, 0, 0, 0, 0, 3, 1, 0, 0); chk(0, P, 1, "ls1_after");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); chk(0, P, 1, "ls1_idle");

        // Zero register and unused operand never stall
        drive(0, 0, 0, 1, 31, 5, 1, 31, 1); chk(0, P, 1, "xzr");
        drive(0, 0, 0, 1, 7, 7, 0, 0, 0);   chk(0, P, 1, "rn_unused");
        drive(0, 0, 0, 1, 7, 0, 0, 7, 1);   chk(0, S, 1, "rm_used");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);   chk(0, P, 2, "rm_after");

        // Branch with simultaneous luh, BR_PENALTY=2
        drive(0, 0, 1, 1, 4, 4, 1, 0, 0); chk(0, BR, 2, "br_cyc0");
        drive(0, 0, 0, 1, 4, 4, 1, 0, 0); chk(0, BF, 2, "br_cyc1");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); chk(0, P, 2, "br_cyc2");

        // Reset during BFLUSH
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0); chk(0, BR, 2, "brr_cyc0");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0); chk(0, P, 2, "brr_rst");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); chk(0, P, 0, "brr_after");
        drive(0, 0, 0, 1, 2, 2, 1, 0, 0); chk(0, S, 0, "brr_run");

        // LOAD_STALL=3 with a 2-cycle freeze mid-stall
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 3, 3, 1, 0, 0); chk(1, S, 0, "ls3_c0");
        drive(0, 0, 0, 1, 3, 3, 1, 0, 0); chk(1, S, 1, "ls3_c1");
        drive(0, 1, 0, 1, 3, 3, 1, 0, 0); chk(1, F, 2, "ls3_frz0");
        drive(0, 1, 0, 1, 3, 3, 1, 0, 0); chk(1, F, 3, "ls3_frz1");
        drive(0, 0, 0, 1, 3, 3, 1, 0, 0); chk(1, S, 4, "ls3_c2");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); chk(1, P, 5, "ls3_done");

        // Saturation of a 4-bit counter
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0); chk(1, P, 5, "sat_rst");
        for (int k = 0; k < 20; k++) begin
            drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
            chk(1, F, (k > 15) ? 15 : k, "sat_frz");
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); chk(1, P, 15, "sat_end");

        // LOAD_STALL=4, branch in the third stall cycle
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 3, 3, 1, 0, 0); chk(2, S, 0, "ls4_c0");
        drive(0, 0, 0, 1, 3, 3, 1, 0, 0); chk(2, S, 1, "ls4_c1");
        drive(0, 0, 1, 1, 3, 3, 1, 0, 0); chk(2, BR, 2, "ls4_br");
        drive(0, 0, 0, 1, 3, 3, 1, 0, 0); chk(2, BF, 2, "ls4_bflush");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); chk(2, P, 2, "ls4_done");

        // Freeze in the middle of BFLUSH extends it
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0); chk(2, BR, 2, "bfz_br");
        drive(0, 1, 1, 0, 0, 0, 0, 0, 0); chk(2, F, 2, "bfz_frz");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); chk(2, BF, 3, "bfz_flush");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); chk(2, P, 3, "bfz_done");

        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
